// File: rtl/iter_mul_wb_pkg.sv
// iter_mul_wb_pkg: shared state encoding and register-index width for the iterative multiplier.
package iter_mul_wb_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_e;
endpackage

// File: rtl/iter_mul_core.sv
// iter_mul_core: shift-add accumulator, multiplier shifter and step counter for one multiply.
module iter_mul_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, shifted;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mplier_q[0] ? mcand_q : {WIDTH{1'b0}}};
    shifted  = {sum, acc_q[WIDTH-1:1]};
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (load) begin
      mcand_d  = (signed_op && a[WIDTH-1]) ? -a : a;
      mplier_d = (signed_op && b[WIDTH-1]) ? -b : b;
      neg_d    = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (step) begin
      // the sign fix-up rides on the final step so the product is ready when WR_LO begins
      acc_d    = (finish && neg_q) ? -shifted : shifted;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end
  assign last     = cnt_q == CW'(1);
  assign acc      = acc_q;
  assign acc_next = acc_d;
endmodule

// File: rtl/iter_mul_wb.sv
// iter_mul_wb: multi-cycle multiplier that writes its product back through the register file write port.
module iter_mul_wb
  import iter_mul_wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HI_REG   = 31,
  parameter bit WRITE_HI = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  input  logic [REG_AW-1:0] dest_add,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] wr_add,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_enable
);
  localparam logic [REG_AW-1:0] HI_ADD = REG_AW'(HI_REG);
  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [REG_AW-1:0]  wr_add_q, wr_add_d, dest_q, dest_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               load, step, finish, last;
  logic [2*WIDTH-1:0] acc, acc_next;
  iter_mul_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .signed_op (signed_op),
    .a         (rs_val),
    .b         (rt_val),
    .last      (last),
    .acc       (acc),
    .acc_next  (acc_next)
  );
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    dest_d    = dest_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        dest_d  = dest_add;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step   = 1'b1;
        busy_d = 1'b1;
        if (last) begin
          finish    = 1'b1;
          state_d   = WR_LO;
          wr_en_d   = 1'b1;
          wr_add_d  = dest_q;
          wr_data_d = acc_next[WIDTH-1:0];
          done_d    = !WRITE_HI;
        end
      end
      WR_LO: if (WRITE_HI) begin
        state_d   = WR_HI;
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_add_d  = HI_ADD;
        wr_data_d = acc[2*WIDTH-1:WIDTH];
        done_d    = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      dest_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      dest_q    <= dest_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_enable = wr_en_q;
  assign wr_add    = wr_add_q;
  assign wr_data   = wr_data_q;
endmodule
